reg_bank_ab: RTL
================

Name: reg_bank_ab

Overview:
- 32 x 32-bit general-purpose register bank for the multicycle MIPS datapath, directly downstream of the write-register-address mux.
- Consumes the 5-bit write address the mux produces (rt, $29, $31 or rd) together with the write-back data and RegWrite.
- Provides two combinational read ports, plus the registered A/B operand latches that feed the ALU-source muxes.

Parameters:
- DATA_WIDTH, 32, width of each register and of all data ports
- SP_INDEX, 29, index of the stack pointer register
- STACK_TOP, 227, reset value loaded into register SP_INDEX

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- reg_write  input  1  write enable for the bank
- write_reg  input  5  destination register index from the write-register mux
- write_data  input  DATA_WIDTH  write-back value
- read_reg1  input  5  source index rs
- read_reg2  input  5  source index rt
- ab_load  input  1  capture the read ports into A/B
- read_data1  output  DATA_WIDTH  combinational contents of read_reg1
- read_data2  output  DATA_WIDTH  combinational contents of read_reg2
- a_out  output  DATA_WIDTH  registered operand A
- b_out  output  DATA_WIDTH  registered operand B

Behaviour:
- Reset (asynchronous, while reset=1):
  - all registers are 0, except register SP_INDEX = STACK_TOP.
  - a_out = 0 and b_out = 0.
  - Writes are ignored while reset is high.
- Reset asserted mid-write: the reset value wins and the write is lost.
- Write:
  - on a rising clk edge with reg_write=1 and write_reg != 0, register[write_reg] <= write_data.
  - Latency is 1 cycle; the new value is visible on the read ports after that edge.
- Register 0:
  - always reads 0.
  - Writes to it are discarded with no side effect.
  - This includes a write addressed to 0 with reg_write=1.
- Register SP_INDEX is an ordinary register after reset: fully readable and writable.
- Read ports:
  - purely combinational from the current array contents.
  - Index 0 returns 0.
  - read_reg1 = read_reg2 is legal; both ports return the same value.
- A/B latches:
  - on a rising edge with ab_load=1, a_out <= read_data1 and b_out <= read_data2.
  - With ab_load=0, a_out and b_out hold.
  - Latency from read_reg change to a_out/b_out is 1 cycle when ab_load=1.
- Simultaneous write and A/B load to the same index, without the optional feature:
  - A/B capture the pre-write (old) register contents.
  - The array takes the new value on the same edge.
- Out-of-range indices: none exist; all 5-bit values are valid.
- No other state: there are no busy or stall signals, and every operation completes in the cycle it is issued.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN
- Defined:
  - write-through forwarding is active.
  - When reg_write=1, write_reg != 0 and write_reg equals read_reg1 (or read_reg2), read_data1 (or read_data2) returns write_data combinationally.
  - An ab_load on that edge therefore captures the new value into a_out/b_out.
  - Index 0 is never forwarded.
- Undefined:
  - no forwarding; read ports show array contents only.
  - Same-edge A/B load captures the old value, as stated in Behaviour.

Test Plan:
- Reset values: pulse reset mid-cycle (asynchronous, not clock-aligned) -> read_reg1=29 gives read_data1=227; read_reg2=5 gives 0; a_out=b_out=0 immediately.
- Basic write/read:
  - write 0xDEADBEEF to reg 8 with reg_write=1 -> next cycle read_reg1=8 gives 0xDEADBEEF.
  - ab_load=1 with read_reg1=8, read_reg2=29 -> a_out=0xDEADBEEF, b_out=227 after one edge.
- Register 0: reg_write=1, write_reg=0, write_data=0x12345678 -> read_reg1=0 still reads 0; no other register changes.
- $31/$29 destinations: write 0x00000040 to 31, then 0x000000E0 to 29 -> both read back; reset then restores 29 to 227 and 31 to 0.
- Same-edge write + ab_load to reg 9 (old 0x11, new 0x22):
  - without REG_BANK_BYPASS_EN -> a_out=0x11, and reg 9 reads 0x22 next cycle.
  - with REG_BANK_BYPASS_EN -> a_out=0x22 and read_data1 shows 0x22 in the same cycle.
- Reset mid-write: assert reset while reg_write=1, write_reg=10, write_data=0xFF -> reg 10 reads 0 after reset deasserts; A/B hold at 0 until the next ab_load.

Source files
------------

// File: rtl/reg_bank_ab.sv
// 32 x DATA_WIDTH register bank with two combinational read ports and registered A/B operand latches.
// Optional write-through forwarding on the read ports when REG_BANK_BYPASS_EN is defined.
module reg_bank_ab #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SP_INDEX   = 29,
  parameter int unsigned STACK_TOP  = 227
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [4:0]            write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_reg1,
  input  logic [4:0]            read_reg2,
  input  logic                  ab_load,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  output logic [DATA_WIDTH-1:0] a_out,
  output logic [DATA_WIDTH-1:0] b_out
);

  localparam int unsigned NUM_REGS = 32;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_arr1;
  logic [DATA_WIDTH-1:0] w_arr2;

  assign w_wr_en = reg_write && (write_reg != 5'd0);

  // Register array; register 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == SP_INDEX) ? DATA_WIDTH'(STACK_TOP) : '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  assign w_arr1 = (read_reg1 == 5'd0) ? '0 : r_regs[read_reg1];
  assign w_arr2 = (read_reg2 == 5'd0) ? '0 : r_regs[read_reg2];

`ifdef REG_BANK_BYPASS_EN
  // Forward the in-flight write so a same-edge A/B load sees the new value.
  always_comb begin
    read_data1 = w_arr1;
    read_data2 = w_arr2;
    if (w_wr_en && (write_reg == read_reg1)) read_data1 = write_data;
    if (w_wr_en && (write_reg == read_reg2)) read_data2 = write_data;
  end
`else
  always_comb begin
    read_data1 = w_arr1;
    read_data2 = w_arr2;
  end
`endif

  // A/B operand latches feeding the ALU-source muxes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else if (ab_load) begin
      r_a <= read_data1;
      r_b <= read_data2;
    end
  end

  assign a_out = r_a;
  assign b_out = r_b;

endmodule
